// File: rtl/regfile_pkg.sv
// Shared constants for the WISC register file and the stages that talk to it.
// Address width is derived from the register count so decode/writeback agree on it.
package regfile_pkg;

    localparam int DATA_W_DEF   = 16;
    localparam int NUM_REGS_DEF = 16;

    // A two-entry file still needs a one-bit address.
    function automatic int addr_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: set on issue, cleared on writeback.
// If a register is issued and cleared in the same cycle, the issue wins.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int ZERO_R0  = 0,
    localparam int AW      = addr_w(NUM_REGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                iss_en_i,
    input  logic [AW-1:0]       iss_addr_i,
    input  logic                clr_en_i,
    input  logic [AW-1:0]       clr_addr_i,
    output logic [NUM_REGS-1:0] busy_o
);

    logic [NUM_REGS-1:0] busy_q, busy_d;

    always_comb begin
        busy_d = busy_q;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (iss_en_i && (int'(iss_addr_i) == r))
                busy_d[r] = 1'b1;
            else if (clr_en_i && (int'(clr_addr_i) == r))
                busy_d[r] = 1'b0;
        end
        // A hardwired-zero R0 never has a producer in flight.
        if (ZERO_R0 != 0)
            busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            busy_q <= '0;
        else
            busy_q <= busy_d;
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/regfile_sb.sv
// Mux-read register file with optional write bypass, optional zero R0,
// and a busy scoreboard that decode uses to stall on outstanding writes.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int NUM_RD   = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_R0  = 0,
    localparam int AW      = addr_w(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [AW-1:0]            wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [NUM_RD*AW-1:0]     rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     iss_en,
    input  logic [AW-1:0]            iss_addr,
    output logic [NUM_REGS-1:0]      busy_vec
);

    logic [NUM_REGS-1:0][DATA_W-1:0] mem_q, mem_d;
    logic                            wr_ok;

    assign wr_ok = wr_en && !((ZERO_R0 != 0) && (wr_addr == '0));

    always_comb begin
        mem_d = mem_q;
        if (wr_ok)
            mem_d[wr_addr] = wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            mem_q <= '0;
        else
            mem_q <= mem_d;
    end

    // The raw write enable clears busy; the scoreboard itself pins R0 idle.
    regfile_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ZERO_R0  (ZERO_R0)
    ) u_sb (
        .clk        (clk),
        .rst_n      (rst_n),
        .iss_en_i   (iss_en),
        .iss_addr_i (iss_addr),
        .clr_en_i   (wr_en),
        .clr_addr_i (wr_addr),
        .busy_o     (busy_vec)
    );

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        logic [AW-1:0] ra;
        logic          is_zero;
        logic          hit;

        assign ra      = rd_addr[g*AW +: AW];
        assign is_zero = (ZERO_R0 != 0) && (ra == '0);
        assign hit     = (BYPASS != 0) && wr_en && (wr_addr == ra);

        assign rd_data[g*DATA_W +: DATA_W] = is_zero ? '0 :
                                             hit     ? wr_data : mem_q[ra];
        // A retiring write in this cycle already satisfies the reader.
        assign rd_busy[g] = !is_zero && busy_vec[ra] && !hit;
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed checks for regfile_sb across three configurations:
// default bypass, no-bypass with zero R0, and a wide 32x32 three-port file.
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    // Shared stimulus for the two 16x16 two-port instances.
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic [7:0]  rd_addr = '0;
    logic        iss_en = 1'b0;
    logic [3:0]  iss_addr = '0;

    logic [31:0] rd_data_a, rd_data_z;
    logic [1:0]  rd_busy_a, rd_busy_z;
    logic [15:0] busy_vec_a, busy_vec_z;

    logic        w_wr_en = 1'b0;
    logic [4:0]  w_wr_addr = '0;
    logic [31:0] w_wr_data = '0;
    logic [14:0] w_rd_addr = '0;
    logic        w_iss_en = 1'b0;
    logic [4:0]  w_iss_addr = '0;
    logic [95:0] w_rd_data;
    logic [2:0]  w_rd_busy;
    logic [31:0] w_busy_vec;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    regfile_sb u_dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
        .iss_en(iss_en), .iss_addr(iss_addr), .busy_vec(busy_vec_a)
    );

    regfile_sb #(.BYPASS(0), .ZERO_R0(1)) u_nb (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data_z), .rd_busy(rd_busy_z),
        .iss_en(iss_en), .iss_addr(iss_addr), .busy_vec(busy_vec_z)
    );

    regfile_sb #(.DATA_W(32), .NUM_REGS(32), .NUM_RD(3)) u_wide (
        .clk(clk), .rst_n(rst_n),
        .wr_en(w_wr_en), .wr_addr(w_wr_addr), .wr_data(w_wr_data),
        .rd_addr(w_rd_addr), .rd_data(w_rd_data), .rd_busy(w_rd_busy),
        .iss_en(w_iss_en), .iss_addr(w_iss_addr), .busy_vec(w_busy_vec)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance to just past the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        #1;
        chk("rst_rd_a",   rd_data_a,  32'h0);
        chk("rst_bv_a",   busy_vec_a, 16'h0);
        chk("rst_rb_a",   rd_busy_a,  2'b00);
        chk("rst_bv_z",   busy_vec_z, 16'h0);
        chk("rst_wbv",    w_busy_vec, 32'h0);
        #6 rst_n = 1'b1;
        tick();

        // Same-cycle write/read of R5 on both ports
        wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'h1234; rd_addr = {4'd5, 4'd5};
        #1;
        chk("byp_rd_a",   rd_data_a,  32'h1234_1234);
        chk("nobyp_rd_z", rd_data_z,  32'h0000_0000);
        tick();
        wr_en = 1'b0;
        #1;
        chk("wr_rd_a",    rd_data_a,  32'h1234_1234);
        chk("wr_rd_z",    rd_data_z,  32'h1234_1234);

        // Asynchronous reset mid-cycle with live data and a busy bit
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'hBEEF;
        iss_en = 1'b1; iss_addr = 4'd9;
        tick();
        wr_en = 1'b0; iss_en = 1'b0; rd_addr = {4'd3, 4'd3};
        #1;
        chk("pre_rst_rd", rd_data_a,  32'hBEEF_BEEF);
        chk("pre_rst_bv", busy_vec_a, 16'h0200);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_rd_a",  rd_data_a,  32'h0);
        chk("arst_bv_a",  busy_vec_a, 16'h0);
        chk("arst_rd_z",  rd_data_z,  32'h0);
        rst_n = 1'b1;
        tick();

        // R0: hardwired zero on u_nb, ordinary register on u_dut
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'hFFFF;
        iss_en = 1'b1; iss_addr = 4'd0; rd_addr = {4'd0, 4'd0};
        #1;
        chk("z0_rd_z",    rd_data_z,  32'h0);
        chk("z0_rb_z",    rd_busy_z,  2'b00);
        chk("z0_rd_a",    rd_data_a,  32'hFFFF_FFFF);
        tick();
        wr_en = 1'b0; iss_en = 1'b0;
        #1;
        chk("z0_rd_z2",   rd_data_z,  32'h0);
        chk("z0_rb_z2",   rd_busy_z,  2'b00);
        chk("z0_bv_z",    busy_vec_z, 16'h0);
        chk("r0_bv_a",    busy_vec_a, 16'h0001);
        chk("r0_rd_a",    rd_data_a,  32'hFFFF_FFFF);
        chk("r0_rb_a",    rd_busy_a,  2'b11);
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'h0000;
        tick();
        wr_en = 1'b0;
        #1;
        chk("r0_clr_bv",  busy_vec_a, 16'h0);

        // Scoreboard: issue R7, busy for three cycles, then writeback
        iss_en = 1'b1; iss_addr = 4'd7; rd_addr = {4'd7, 4'd7};
        #1;
        chk("sb_c0_rb",   rd_busy_a,  2'b00);
        tick();
        iss_en = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            #1;
            chk($sformatf("sb_c%0d_rb_a", c), rd_busy_a, 2'b11);
            chk($sformatf("sb_c%0d_rb_z", c), rd_busy_z, 2'b11);
            tick();
        end
        wr_en = 1'b1; wr_addr = 4'd7; wr_data = 16'h00AA;
        #1;
        chk("sb_c4_rb_a", rd_busy_a,  2'b00);
        chk("sb_c4_rd_a", rd_data_a,  32'h00AA_00AA);
        chk("sb_c4_rb_z", rd_busy_z,  2'b11);
        chk("sb_c4_rd_z", rd_data_z,  32'h0);
        tick();
        wr_en = 1'b0;
        #1;
        chk("sb_c5_rb_z", rd_busy_z,  2'b00);
        chk("sb_c5_rd_z", rd_data_z,  32'h00AA_00AA);
        chk("sb_c5_bv_a", busy_vec_a, 16'h0);

        // Double issue of R4 is cleared by a single write
        iss_en = 1'b1; iss_addr = 4'd4;
        tick();
        tick();
        iss_en = 1'b0;
        #1;
        chk("dbl_bv",     busy_vec_a, 16'h0010);
        wr_en = 1'b1; wr_addr = 4'd4; wr_data = 16'h0044;
        tick();
        wr_en = 1'b0;
        #1;
        chk("dbl_clr_bv", busy_vec_a, 16'h0);

        // Simultaneous issue and clear of R2: issue wins, data lands
        iss_en = 1'b1; iss_addr = 4'd2;
        tick();
        wr_en = 1'b1; wr_addr = 4'd2; wr_data = 16'h5555; rd_addr = {4'd2, 4'd2};
        #1;
        chk("sim_byp_rb", rd_busy_a,  2'b00);
        tick();
        wr_en = 1'b0; iss_en = 1'b0;
        #1;
        chk("sim_bv_a",   busy_vec_a, 16'h0004);
        chk("sim_rd_a",   rd_data_a,  32'h5555_5555);
        chk("sim_rb_a",   rd_busy_a,  2'b11);

        // Wide configuration: R31 on all three ports
        w_wr_en = 1'b1; w_wr_addr = 5'd31; w_wr_data = 32'hDEADBEEF;
        w_rd_addr = {5'd31, 5'd31, 5'd31};
        #1;
        chk("w_byp_rd",   w_rd_data,  96'hDEADBEEF_DEADBEEF_DEADBEEF);
        tick();
        w_wr_en = 1'b0;
        #1;
        chk("w_rd_all",   w_rd_data,  96'hDEADBEEF_DEADBEEF_DEADBEEF);
        w_rd_addr = {5'd31, 5'd1, 5'd31};
        #1;
        chk("w_rd_mix",   w_rd_data,  96'hDEADBEEF_00000000_DEADBEEF);
        w_iss_en = 1'b1; w_iss_addr = 5'd30;
        tick();
        w_iss_en = 1'b0;
        w_rd_addr = {5'd30, 5'd31, 5'd30};
        #1;
        chk("w_bv",       w_busy_vec, 32'h4000_0000);
        chk("w_rb",       w_rd_busy,  3'b101);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised register file for the WISC CPU core, with scoreboard-based hazard tracking. Register width, register count and read-port count are configurable. Reads use multiplexers rather than tristate bitlines. The block adds optional write-to-read bypass, an optional hardwired-zero register 0, and a per-register busy scoreboard. The scoreboard lets the decode stage stall on registers that have a write outstanding. It sits between decode (reads, issue) and writeback (write, busy clear).

## Interface
Parameters:
- DATA_W, 16: width of each register in bits.
- NUM_REGS, 16: number of registers; power of two, minimum 2.
- NUM_RD, 2: number of read ports, 1 to 4.
- BYPASS, 1: when 1, a same-cycle write is forwarded to matching read ports.
- ZERO_R0, 0: when 1, register 0 always reads 0, is never written and is never busy.

Ports (AW = clog2(NUM_REGS)):
- clk  in  1  global clock, rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  writeback write enable.
- wr_addr  in  AW  writeback destination register.
- wr_data  in  DATA_W  writeback data.
- rd_addr  in  NUM_RD*AW  packed read addresses; port i uses bits [i*AW +: AW].
- rd_data  out  NUM_RD*DATA_W  packed read data, combinational.
- rd_busy  out  NUM_RD  per read port; 1 = the addressed register has an outstanding write.
- iss_en  in  1  decode issue: marks iss_addr busy.
- iss_addr  in  AW  destination register of the issuing instruction.
- busy_vec  out  NUM_REGS  raw scoreboard contents, for debug and forwarding logic.

## Operation
- Storage is NUM_REGS × DATA_W flops. On reset, every register is 0 and every busy bit is 0.
- **Write:** when wr_en=1, mem[wr_addr] <= wr_data at the rising edge. If ZERO_R0=1 and wr_addr=0, the write is dropped.
- **Read:** rd_data[i] = mem[rd_addr[i]], purely combinational, with these overrides:
  - If ZERO_R0=1 and rd_addr[i]=0, the output is 0.
  - Else if BYPASS=1, wr_en=1 and wr_addr==rd_addr[i], the output is wr_data.
- **Scoreboard, next state per register r:**
  - Set if iss_en && iss_addr==r.
  - Else clear if wr_en && wr_addr==r.
  - Else hold.
  - Issue and clear of the same register in the same cycle: set wins, because the new producer supersedes the retiring one. The write still updates mem.
- **rd_busy[i]:** busy[rd_addr[i]] & ~(BYPASS && wr_en && wr_addr==rd_addr[i]). It is forced to 0 when ZERO_R0=1 and rd_addr[i]=0.
- **Register 0 with ZERO_R0=1:** iss_en to register 0 is ignored, and busy[0] is constant 0.
- **Double issue:** issuing an already-busy register leaves it busy. There is no counting; one write clears it.
- **Clearing an idle register:** a write to a non-busy register is legal and leaves busy at 0.
- **Reset mid-operation:** asserting rst_n low immediately and asynchronously zeroes mem and busy. rd_data shows 0 from that point, subject to the bypass and zero overrides.

## Timing
- Read latency is 0 cycles (combinational from rd_addr, wr_*, and state).
- Write latency is 1 cycle without bypass. With BYPASS=1 it is visible in the same cycle.
- An issue shows in rd_busy in the cycle after iss_en.
- A clear drops rd_busy in the same cycle when BYPASS=1; otherwise in the next cycle.
- No handshake. All inputs are sampled at the rising edge of clk. Outputs reset to: rd_data=0, rd_busy=0, busy_vec=0.

## Structure
- Package regfile_pkg holds:
  - clog2-based AW computation.
  - Default DATA_W / NUM_REGS constants shared with the decode and writeback stages.
- Sub-module regfile_scoreboard holds the busy vector, the set/clear priority and busy_vec.
  - Parameters: NUM_REGS and ZERO_R0.
  - The top level adds storage, read muxes and the bypass/zero overrides.
- Read ports are generated with a generate loop over NUM_RD.

## Test plan
- **Reset:** write 0xBEEF to R3, then pulse rst_n low mid-cycle → rd_data for R3 reads 0x0000 immediately and busy_vec = 0.
- **Write/read:** write 0x1234 to R5 and read R5 on both ports in the same cycle:
  - BYPASS=1 → both ports show 0x1234 in that cycle.
  - BYPASS=0 → both show 0x0000, then 0x1234 the next cycle.
- **Zero register:** ZERO_R0=1, write 0xFFFF to R0 and iss_en to R0 → reads stay 0x0000; rd_busy stays 0; busy_vec[0] stays 0.
- **Scoreboard:** iss_en R7 in cycle 0 → rd_busy=1 for R7 in cycles 1–3. Write R7=0x00AA in cycle 4 → with BYPASS=1, rd_busy=0 and rd_data=0x00AA in cycle 4.
- **Simultaneous issue and clear:** R2 busy; iss_en R2 and wr_en R2=0x5555 in the same cycle → next cycle busy[2]=1 and mem[2]=0x5555.
- **Parametrisation:** NUM_REGS=32, DATA_W=32, NUM_RD=3. Write 0xDEADBEEF to R31 → all three ports addressed to R31 read 0xDEADBEEF; other ports unaffected.
